sm_arith_unit: RTL

Parametrised, sequential sign-magnitude arithmetic unit for the accumulator datapath. It extends the single-cycle combinational 16-bit sign-magnitude adder with configurable width, a SUB/NEG mode, an iterative shift-add multiplier, a start/done handshake and status flags. It sits between the accumulator/operand registers and the writeback mux. The control FSM drives `start` and waits for `done`.

---
 rtl/sm_arith_unit_if.sv | 26 ++
 rtl/sm_arith_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sm_arith_unit_if.sv
// Handshake and operand/result bundle for the sign-magnitude arithmetic unit.
// The control FSM sits on the master side and the unit on the slave side.
interface sm_arith_unit_if #(
  parameter int WIDTH = 16
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_ready;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_ovf;
  logic             o_zero;
  logic             o_neg;

  modport master (
    output i_start, i_op, i_a, i_b,
    input  o_ready, o_done, o_result, o_ovf, o_zero, o_neg
  );

  modport slave (
    input  i_start, i_op, i_a, i_b,
    output o_ready, o_done, o_result, o_ovf, o_zero, o_neg
  );
endinterface

// File: rtl/sm_arith_unit.sv
// Sign-magnitude arithmetic unit: single-cycle ADD/SUB/NEG and an iterative
// shift-add multiplier, with a start/done handshake and result flags.
// Negative zero is never produced; zero magnitudes always carry sign 0.
module sm_arith_unit #(
  parameter int WIDTH = 16
) (
  input logic            i_clk,
  input logic            i_rst_n,
  sm_arith_unit_if.slave io_bus
);
  localparam int N  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;

  logic [N-1:0]     w_magA;
  logic [N-1:0]     w_magB;
  logic             w_signA;
  logic             w_signBEff;
  logic [N:0]       w_sum;
  logic [N-1:0]     w_aluMag;
  logic             w_aluSign;
  logic             w_aluOvf;

  logic [2*N-1:0]   r_mcand;
  logic [2*N-1:0]   r_prod;
  logic [2*N-1:0]   w_prodNext;
  logic [N-1:0]     r_mplier;
  logic             r_sign;
  logic [CW-1:0]    r_count;
  logic [N-1:0]     w_mulMag;
  logic             w_mulOvf;

  logic [WIDTH-1:0] r_result;
  logic             r_ovf;
  logic             r_zero;
  logic             r_done;

  logic             w_accept;
  logic             w_mulLast;

  // A zero magnitude is treated as +0 regardless of its sign bit; SUB flips b's sign.
  assign w_magA     = io_bus.i_a[N-1:0];
  assign w_magB     = io_bus.i_b[N-1:0];
  assign w_signA    = io_bus.i_a[WIDTH-1] & (|w_magA);
  assign w_signBEff = (io_bus.i_b[WIDTH-1] & (|w_magB)) ^ (io_bus.i_op == OP_SUB);
  assign w_sum      = {1'b0, w_magA} + {1'b0, w_magB};

  assign w_accept   = (r_state == IDLE) && io_bus.i_start;
  assign w_mulLast  = (r_state == MUL_RUN) && (r_count == CW'(1));

  // One multiplier step: add the shifted multiplicand when the current multiplier bit is set.
  assign w_prodNext = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mulMag   = w_prodNext[N-1:0];
  assign w_mulOvf   = |w_prodNext[2*N-1:N];

  // Single-cycle sign-magnitude add/subtract/negate.
  always_comb begin
    w_aluMag  = '0;
    w_aluSign = 1'b0;
    w_aluOvf  = 1'b0;
    case (io_bus.i_op)
      OP_NEG: begin
        w_aluMag  = w_magA;
        w_aluSign = ~w_signA;
      end
      OP_ADD, OP_SUB: begin
        if (w_signA == w_signBEff) begin
          w_aluMag  = w_sum[N-1:0];
          w_aluSign = w_signA;
          w_aluOvf  = w_sum[N];
        end else if (w_magA >= w_magB) begin
          w_aluMag  = w_magA - w_magB;
          w_aluSign = w_signA;
        end else begin
          w_aluMag  = w_magB - w_magA;
          w_aluSign = w_signBEff;
        end
      end
      default: begin
        w_aluMag  = '0;
        w_aluSign = 1'b0;
        w_aluOvf  = 1'b0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: only a multiply leaves IDLE, and it returns on its last step.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && (io_bus.i_op == OP_MUL)) begin
          w_stateNext = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (w_mulLast) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Operand capture, multiplier iteration and registered result/flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_sign   <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (io_bus.i_op == OP_MUL) begin
          r_mcand  <= {{N{1'b0}}, w_magA};
          r_mplier <= w_magB;
          r_sign   <= io_bus.i_a[WIDTH-1] ^ io_bus.i_b[WIDTH-1];
          r_prod   <= '0;
          r_count  <= CW'(N);
        end else begin
          r_result <= {w_aluSign & (|w_aluMag), w_aluMag};
          r_ovf    <= w_aluOvf;
          r_zero   <= ~(|w_aluMag);
          r_done   <= 1'b1;
        end
      end else if (r_state == MUL_RUN) begin
        r_prod   <= w_prodNext;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count - CW'(1);
        if (w_mulLast) begin
          r_result <= {r_sign & (|w_mulMag), w_mulMag};
          r_ovf    <= w_mulOvf;
          r_zero   <= ~(|w_mulMag);
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign io_bus.o_ready  = (r_state == IDLE);
  assign io_bus.o_done   = r_done;
  assign io_bus.o_result = r_result;
  assign io_bus.o_ovf    = r_ovf;
  assign io_bus.o_zero   = r_zero;
  assign io_bus.o_neg    = r_result[WIDTH-1];
endmodule
